tof_hist_axi_writer: RTL and testbench
======================================

Name: tof_hist_axi_writer

Overview:
Downstream write-back stage of the TOF core: moves one finished 16-stop-channel histogram (256 bytes, 16 x 128-bit beats) from the core's local histogram SRAM into DRAM through the AXI4 write channels. The core issues one request per histogram with frame_id/hist_id. The block computes the address, fetches beats from the SRAM (1-cycle read latency) into a 2-entry prefetch FIFO, runs one INCR burst and reports completion or error.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 128, AXI data / SRAM word width
BASE_ADDR, 32'h0001_0000, DRAM base of frame area
BEATS, 16, beats per histogram (awlen = BEATS-1)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  write-back request
req_ready  out  1  high only in IDLE
req_frame_id  in  5  frame 0..31
req_hist_id  in  4  histogram 0..15 within frame
sram_rd_en  out  1  SRAM read strobe
sram_rd_addr  out  4  beat index within histogram
sram_rd_data  in  DATA_WIDTH  valid one cycle after sram_rd_en
busy  out  1  high from accepted request until done
done  out  1  one-cycle pulse when B response received
err  out  1  sticky; set when bresp != 2'b00; cleared on next accepted request
awid_m_inf, awaddr_m_inf, awlen_m_inf(8), awsize_m_inf(3), awburst_m_inf(2), awvalid_m_inf  out;  awready_m_inf  in
wdata_m_inf(DATA_WIDTH), wlast_m_inf, wvalid_m_inf  out;  wready_m_inf  in
bid_m_inf(ID_WIDTH), bresp_m_inf(2), bvalid_m_inf  in;  bready_m_inf  out

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; busy, done, err, awvalid, wvalid, wlast, bready, sram_rd_en = 0; awaddr, wdata = 0; FIFO empty; counters 0.
- Constants: awid=0, awlen=BEATS-1 (15), awsize=3'b100, awburst=2'b01.
- Address: awaddr = BASE_ADDR + {frame_id,12'h000} + {hist_id,8'h00}, latched at request acceptance; frame 31/hist 15 -> 32'h0002_FF00.
- States: IDLE -> AW on req_valid&&req_ready (latch ids, clear err, busy=1). AW: awvalid=1 held until awready; fire -> W. W: wvalid=!fifo_empty; beat advances on wvalid&&wready; wlast=1 when beat count==15; last handshake -> B. B: bready=1; bvalid&&bready -> IDLE, done=1 for 1 cycle, err |= (bresp!=0), busy=0.
- Prefetch: starts at entry to AW. Issue sram_rd_en with rd_addr=next index when (fifo occupancy + reads in flight) < 2 and issued < 16. Data written into FIFO the cycle after rd_en. FIFO pop on W handshake; simultaneous push+pop keeps occupancy. Beats leave in order 0..15. No reads issued after index 15.
- AXI rules: awvalid/wvalid and payload stable until handshake. No W before AW handshake. No combinational path from ready inputs to valid outputs. wready low for any number of cycles must not lose or duplicate beats.
- Throughput: wready held high -> 16 consecutive W beats, no bubbles.
- req_valid ignored while busy. bid not checked. Reset mid-burst aborts immediately to reset values; no recovery burst.

Decomposition:
- Shared package tof_pkg: AXI constants (AXI_SIZE_16B, AXI_BURST_INCR, AXI_RESP_OKAY), BASE_ADDR, BEATS, state enum typedef, address-compute function.
- One sub-module: tof_prefetch_fifo (2-entry DATA_WIDTH FIFO with push/pop/occupancy); the rest stays inline.

Test Plan:
- Single request frame 0, hist 0, awready/wready/bvalid immediate, bresp=0 -> awaddr=32'h0001_0000, 16 beats with data = SRAM words 0..15, wlast only on beat 16, done pulse, err=0.
- frame 31, hist 15 -> awaddr=32'h0002_FF00, awlen=15, awsize=4, awburst=1.
- wready toggled randomly (including 5-cycle low during beat 7) -> beats remain in order, each exactly once, wvalid/wdata stable while stalled.
- awready delayed 10 cycles -> no wvalid before AW handshake; FIFO holds 2 beats; rd_en count stays 2 until W starts.
- bresp=2'b10 -> done pulses, err=1; next request clears err.
- rst asserted at beat 8 -> all outputs return to reset values asynchronously; new request afterwards completes a full correct burst.

Source files
------------

// File: rtl/tof_pkg.sv
// Shared definitions for the TOF histogram write-back path: AXI encodings,
// frame-area layout and the DRAM address helper.
package tof_pkg;

    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    localparam logic [31:0] BASE_ADDR = 32'h0001_0000;
    localparam int          BEATS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } tof_state_e;

    // Each frame owns a 4 KiB slot and each histogram a 256-byte slot in it.
    function automatic logic [31:0] hist_addr(input logic [31:0] base,
                                              input logic [4:0]  frame_id,
                                              input logic [3:0]  hist_id);
        return base + {15'd0, frame_id, 12'h000} + {20'd0, hist_id, 8'h00};
    endfunction

endpackage

// File: rtl/tof_prefetch_fifo.sv
// Two-entry FIFO that holds SRAM beats between the read strobe and the AXI W
// channel. The head is presented combinationally so wdata stays put while stalled.
module tof_prefetch_fifo #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/tof_hist_axi_writer.sv
// Writes one finished 16-beat histogram from local SRAM to DRAM as a single
// AXI4 INCR burst, prefetching SRAM words through a 2-entry FIFO.
module tof_hist_axi_writer
    import tof_pkg::*;
#(
    parameter int          ID_WIDTH   = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 128,
    parameter logic [31:0] BASE_ADDR  = tof_pkg::BASE_ADDR,
    parameter int          BEATS      = tof_pkg::BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_frame_id,
    input  logic [3:0]            req_hist_id,
    output logic                  sram_rd_en,
    output logic [3:0]            sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   awid_m_inf,
    output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
    output logic [7:0]            awlen_m_inf,
    output logic [2:0]            awsize_m_inf,
    output logic [1:0]            awburst_m_inf,
    output logic                  awvalid_m_inf,
    input  logic                  awready_m_inf,
    output logic [DATA_WIDTH-1:0] wdata_m_inf,
    output logic                  wlast_m_inf,
    output logic                  wvalid_m_inf,
    input  logic                  wready_m_inf,
    input  logic [ID_WIDTH-1:0]   bid_m_inf,
    input  logic [1:0]            bresp_m_inf,
    input  logic                  bvalid_m_inf,
    output logic                  bready_m_inf,
    output tof_state_e            state_dbg
);

    localparam int CW = $clog2(BEATS + 1);

    tof_state_e            state, next_state;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         beat_cnt;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic                  done_q;
    logic                  err_q;

    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  req_fire, aw_fire, w_fire, b_fire, last_beat, rd_issue;
    logic                  unused_bid;

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; valid and payload hold until that edge, and
    // no valid output is derived combinationally from a ready input.
    assign req_fire  = req_valid && req_ready;
    assign aw_fire   = awvalid_m_inf && awready_m_inf;
    assign w_fire    = wvalid_m_inf && wready_m_inf;
    assign b_fire    = bvalid_m_inf && bready_m_inf;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    // A pop this cycle frees a slot, so the next read can be issued at once and
    // a continuously-ready W channel never sees a bubble.
    always_comb begin
        rd_issue = 1'b0;
        if ((state == ST_AW || state == ST_W) && (issued < CW'(BEATS))) begin
            rd_issue = ({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, w_fire}) < 3'd2;
        end
    end

    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        busy          = 1'b1;
        awvalid_m_inf = 1'b0;
        wvalid_m_inf  = 1'b0;
        wlast_m_inf   = 1'b0;
        bready_m_inf  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) next_state = ST_AW;
            end
            ST_AW: begin
                awvalid_m_inf = 1'b1;
                if (awready_m_inf) next_state = ST_W;
            end
            ST_W: begin
                wvalid_m_inf = !fifo_empty;
                wlast_m_inf  = last_beat;
                if (w_fire && last_beat) next_state = ST_B;
            end
            ST_B: begin
                bready_m_inf = 1'b1;
                if (bvalid_m_inf) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            issued   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            awaddr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= rd_issue;
            done_q   <= b_fire;
            if (req_fire) begin
                issued   <= '0;
                beat_cnt <= '0;
                awaddr_q <= ADDR_WIDTH'(hist_addr(BASE_ADDR, req_frame_id, req_hist_id));
                err_q    <= 1'b0;
            end else begin
                if (rd_issue) issued   <= issued + CW'(1);
                if (aw_fire || w_fire) beat_cnt <= w_fire ? beat_cnt + CW'(1) : beat_cnt;
            end
            if (b_fire && (bresp_m_inf != AXI_RESP_OKAY)) err_q <= 1'b1;
        end
    end

    tof_prefetch_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (sram_rd_data),
        .pop  (w_fire),
        .dout (fifo_head),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    assign sram_rd_en    = rd_issue;
    assign sram_rd_addr  = issued[3:0];
    assign done          = done_q;
    assign err           = err_q;
    assign awid_m_inf    = '0;
    assign awaddr_m_inf  = awaddr_q;
    assign awlen_m_inf   = 8'(BEATS - 1);
    assign awsize_m_inf  = AXI_SIZE_16B;
    assign awburst_m_inf = AXI_BURST_INCR;
    assign wdata_m_inf   = fifo_head;
    assign state_dbg     = state;
    assign unused_bid    = ^bid_m_inf;

endmodule

// File: tb/tb_tof_hist_axi_writer.sv
// Directed-plus-random bench for tof_hist_axi_writer: an SRAM model, an AXI
// slave with configurable stalls, and a scoreboard of expected beats/addresses.
module tb_tof_hist_axi_writer;
    import tof_pkg::*;

    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [4:0]    req_frame_id;
    logic [3:0]    req_hist_id;
    logic          sram_rd_en;
    logic [3:0]    sram_rd_addr;
    logic [W-1:0]  sram_rd_data;
    logic          busy, done, err;
    logic [3:0]    awid;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [W-1:0]  wdata;
    logic          wlast, wvalid, wready;
    logic [3:0]    bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    tof_state_e    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  sram_mem [16];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];

    int            cfg_aw_delay = 0, cfg_wmode = 0, cfg_stall_beat = -1, stall_left = 0;
    logic [1:0]    cfg_bresp = 2'b00;
    int            aw_wait = 0;

    int            cyc = 0, beats_seen = 0, done_cnt = 0, rd_cnt = 0, rd_at_aw = 0, aw_hs = 0;
    int            w_before_aw = 0, w_unstable = 0, aw_unstable = 0, wlast_bad = 0;
    int            first_w = 0, last_w = 0;
    bit            aw_done = 0, prev_w_stall = 0, prev_aw_stall = 0;
    logic [W-1:0]  prev_wdata;
    logic [31:0]   prev_awaddr, rec_awaddr;
    logic [7:0]    rec_awlen;
    logic [2:0]    rec_awsize;
    logic [1:0]    rec_awburst;
    logic [3:0]    rec_awid;

    tof_hist_axi_writer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_frame_id(req_frame_id), .req_hist_id(req_hist_id),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .busy(busy), .done(done), .err(err),
        .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awlen_m_inf(awlen),
        .awsize_m_inf(awsize), .awburst_m_inf(awburst),
        .awvalid_m_inf(awvalid), .awready_m_inf(awready),
        .wdata_m_inf(wdata), .wlast_m_inf(wlast), .wvalid_m_inf(wvalid), .wready_m_inf(wready),
        .bid_m_inf(bid), .bresp_m_inf(bresp), .bvalid_m_inf(bvalid), .bready_m_inf(bready),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= sram_mem[sram_rd_addr];
    end

    // AXI slave: readies/responses updated just after each rising edge
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
        forever begin
            @(posedge clk); #1;
            aw_wait = awvalid ? aw_wait + 1 : 0;
            awready = awvalid && (aw_wait > cfg_aw_delay);
            if (cfg_stall_beat >= 0 && beats_seen == cfg_stall_beat && wvalid && stall_left > 0) begin
                wready = 1'b0;
                stall_left--;
            end else if (cfg_wmode == 0) begin
                wready = 1'b1;
            end else begin
                wready = 1'($urandom_range(0, 1));
            end
            bvalid = bready;
            bresp  = cfg_bresp;
            bid    = 4'($urandom_range(0, 15));
        end
    end

    // Monitor: samples on the falling edge what the next rising edge will see
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) aw_unstable++;
            if (prev_w_stall && (!wvalid || wdata !== prev_wdata)) w_unstable++;
            prev_aw_stall = awvalid && !awready;
            prev_awaddr   = awaddr;
            prev_w_stall  = wvalid && !wready;
            prev_wdata    = wdata;
            if (wvalid && !aw_done) w_before_aw++;
            if (sram_rd_en) rd_cnt++;
            if (awvalid && awready) begin
                aw_done = 1; aw_hs++; rd_at_aw = rd_cnt;
                rec_awaddr = awaddr; rec_awlen = awlen; rec_awsize = awsize;
                rec_awburst = awburst; rec_awid = awid;
            end
            if (wvalid && wready) begin
                got_q.push_back(wdata);
                if (wlast !== (beats_seen == 15)) wlast_bad++;
                if (beats_seen == 0) first_w = cyc;
                last_w = cyc;
                beats_seen++;
            end
            if (done) done_cnt++;
        end else begin
            prev_aw_stall = 0;
            prev_w_stall  = 0;
        end
    end

    // Scoreboard comparison
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_wlast"}, wlast, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_rd_en"}, sram_rd_en, 0);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_state"}, state_dbg, ST_IDLE);
    endtask

    // Driver: load SRAM, build expectations, issue the request
    task automatic start_req(input logic [4:0] f, input logic [3:0] h, input int awd,
                             input int wmode, input int stall_beat, input logic [1:0] br);
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(sram_mem[i]);
        end
        cfg_aw_delay = awd; cfg_wmode = wmode; cfg_stall_beat = stall_beat;
        cfg_bresp = br; stall_left = 5;
        @(posedge clk); #1;
        beats_seen = 0; done_cnt = 0; rd_cnt = 0; rd_at_aw = 0; aw_hs = 0;
        w_before_aw = 0; w_unstable = 0; aw_unstable = 0; wlast_bad = 0; aw_done = 0;
        req_valid = 1'b1; req_frame_id = f; req_hist_id = h;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_frame_id = 5'($urandom_range(0, 31));
        req_hist_id  = 4'($urandom_range(0, 15));
        tick();
        check("busy_after_accept", busy, 1);
        check("ready_low_when_busy", req_ready, 0);
        check("err_cleared_on_accept", err, 0);
    endtask

    task automatic finish_req(input logic [4:0] f, input logic [3:0] h, input int awd,
                              input int wmode, input int stall_beat, input logic [1:0] br);
        logic [31:0] exp_addr;
        int n;
        exp_addr = 32'h0001_0000 + 32'(f) * 32'h1000 + 32'(h) * 32'h100;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        check("done_seen", 1'(done_cnt > 0), 1);
        tick();
        check("done_one_cycle", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("ready_after_done", req_ready, 1);
        check("err_after_done", err, 1'(br != 2'b00));
        check("aw_handshakes", aw_hs, 1);
        check("awaddr", rec_awaddr, exp_addr);
        check("awlen", rec_awlen, 8'd15);
        check("awsize", rec_awsize, 3'd4);
        check("awburst", rec_awburst, 2'd1);
        check("awid", rec_awid, 4'd0);
        check("aw_stable", aw_unstable, 0);
        check("w_before_aw", w_before_aw, 0);
        check("w_stable", w_unstable, 0);
        check("wlast_position", wlast_bad, 0);
        check("rd_en_count", rd_cnt, 16);
        check("beat_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check($sformatf("beat%0d_data", i), got_q[i], exp_q[i]);
        if (wmode == 0 && stall_beat < 0)
            check("no_bubbles", last_w - first_w, 15);
        if (awd > 0)
            check("prefetch_depth_during_aw", rd_at_aw, 2);
    endtask

    task automatic run_req(input logic [4:0] f, input logic [3:0] h, input int awd,
                           input int wmode, input int stall_beat, input logic [1:0] br);
        start_req(f, h, awd, wmode, stall_beat, br);
        finish_req(f, h, awd, wmode, stall_beat, br);
    endtask

    initial begin
        logic [4:0] f;
        logic [3:0] h;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_frame_id = 5'd0; req_hist_id = 4'd0;
        repeat (3) @(posedge clk);
        tick();
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_req(5'd0, 4'd0, 0, 0, -1, 2'b00);
        run_req(5'd31, 4'd15, 0, 0, -1, 2'b00);
        run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0, 1, 7, 2'b00);
        run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 10, 0, -1, 2'b00);
        run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0, 1, -1, 2'b10);
        run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0, 1, -1, 2'b00);

        // Abort mid-burst with an asynchronous reset
        f = 5'($urandom_range(0, 31));
        h = 4'($urandom_range(0, 15));
        start_req(f, h, 0, 0, -1, 2'b00);
        n = 0;
        while (beats_seen < 8 && n < 1000) begin
            tick();
            n++;
        end
        check("reached_beat8", 1'(beats_seen >= 8), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        check("no_recovery_awvalid", awvalid, 0);
        check("no_recovery_busy", busy, 0);
        run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0, 1, -1, 2'b00);

        for (int k = 0; k < 3; k++) begin
            run_req(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 4), $urandom_range(0, 1), -1,
                    ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
